// File: rtl/ram_2port_arbiter_if.sv
// Bus bundle for ram_2port_arbiter: both client request/response channels
// plus the RAM write/read port signals. Signal names keep their original
// direction prefixes as seen from the arbiter.
interface ram_2port_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    // Client A
    logic             i_a_req;
    logic             i_a_we;
    logic [AW-1:0]    i_a_addr;
    logic [WIDTH-1:0] i_a_wdata;
    logic             o_a_gnt;
    logic             o_a_rd_dv;
    logic [WIDTH-1:0] o_a_rd_data;

    // Client B
    logic             i_b_req;
    logic             i_b_we;
    logic [AW-1:0]    i_b_addr;
    logic [WIDTH-1:0] i_b_wdata;
    logic             o_b_gnt;
    logic             o_b_rd_dv;
    logic [WIDTH-1:0] o_b_rd_data;

    // RAM side
    logic [AW-1:0]    o_wr_addr;
    logic             o_wr_dv;
    logic [WIDTH-1:0] o_wr_data;
    logic [AW-1:0]    o_rd_addr;
    logic             o_rd_en;
    logic             i_rd_dv;
    logic [WIDTH-1:0] i_rd_data;

    // Arbiter side
    modport slave (
        input  i_a_req, i_a_we, i_a_addr, i_a_wdata,
        output o_a_gnt, o_a_rd_dv, o_a_rd_data,
        input  i_b_req, i_b_we, i_b_addr, i_b_wdata,
        output o_b_gnt, o_b_rd_dv, o_b_rd_data,
        output o_wr_addr, o_wr_dv, o_wr_data,
        output o_rd_addr, o_rd_en,
        input  i_rd_dv, i_rd_data
    );

    // Client/RAM-model side
    modport master (
        output i_a_req, i_a_we, i_a_addr, i_a_wdata,
        input  o_a_gnt, o_a_rd_dv, o_a_rd_data,
        output i_b_req, i_b_we, i_b_addr, i_b_wdata,
        input  o_b_gnt, o_b_rd_dv, o_b_rd_data,
        input  o_wr_addr, o_wr_dv, o_wr_data,
        input  o_rd_addr, o_rd_en,
        output i_rd_dv, i_rd_data
    );
endinterface

// File: rtl/ram_2port_arbiter.sv
// Two-client arbiter in front of a dual-port (1W/1R) RAM. Write and read
// ports are arbitrated independently with separate round-robin pointers;
// reads are tagged with the issuing client and the returned data is routed
// back to that client three cycles after the grant.
module ram_2port_arbiter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ram_2port_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        CLI_A = 1'b0,
        CLI_B = 1'b1
    } client_t;

    // Round-robin pointers
    client_t          r_wr_pri;
    client_t          r_rd_pri;

    // RAM port registers
    logic [AW-1:0]    r_wr_addr;
    logic             r_wr_dv;
    logic [WIDTH-1:0] r_wr_data;
    logic [AW-1:0]    r_rd_addr;
    logic             r_rd_en;

    // Read tag pipeline: stage 1 aligned with o_rd_en, stage 2 with i_rd_dv
    logic             r_tag1_v;
    client_t          r_tag1_id;
    logic             r_tag2_v;
    client_t          r_tag2_id;

    // Client read return registers
    logic             r_a_rd_dv;
    logic [WIDTH-1:0] r_a_rd_data;
    logic             r_b_rd_dv;
    logic [WIDTH-1:0] r_b_rd_data;

    // Request classification
    logic             w_a_wr_cand;
    logic             w_b_wr_cand;
    logic             w_a_rd_cand;
    logic             w_b_rd_cand;

    // Arbitration results
    logic             w_wr_gnt_a;
    logic             w_wr_gnt_b;
    logic             w_wr_go;
    logic [AW-1:0]    w_wr_addr;
    logic [WIDTH-1:0] w_wr_data;
    logic             w_rd_sel_a;
    logic             w_rd_sel_b;
    logic [AW-1:0]    w_rd_addr;
    logic             w_hazard;
    logic             w_rd_gnt_a;
    logic             w_rd_gnt_b;
    logic             w_rd_go;

    // Classify pending requests into write and read candidates
    always_comb begin
        w_a_wr_cand = bus.i_a_req &  bus.i_a_we;
        w_b_wr_cand = bus.i_b_req &  bus.i_b_we;
        w_a_rd_cand = bus.i_a_req & ~bus.i_a_we;
        w_b_rd_cand = bus.i_b_req & ~bus.i_b_we;
    end

    // Write-port round-robin arbitration; grants suppressed during reset
    always_comb begin
        w_wr_gnt_a = ~i_rst & w_a_wr_cand & (~w_b_wr_cand | (r_wr_pri == CLI_A));
        w_wr_gnt_b = ~i_rst & w_b_wr_cand & (~w_a_wr_cand | (r_wr_pri == CLI_B));
        w_wr_go    = w_wr_gnt_a | w_wr_gnt_b;
        w_wr_addr  = w_wr_gnt_b ? bus.i_b_addr  : bus.i_a_addr;
        w_wr_data  = w_wr_gnt_b ? bus.i_b_wdata : bus.i_a_wdata;
    end

    // Read-port arbitration; a read colliding with a same-cycle write to the
    // same address is held back so the later read observes the new data
    always_comb begin
        w_rd_sel_a = ~i_rst & w_a_rd_cand & (~w_b_rd_cand | (r_rd_pri == CLI_A));
        w_rd_sel_b = ~i_rst & w_b_rd_cand & (~w_a_rd_cand | (r_rd_pri == CLI_B));
        w_rd_addr  = w_rd_sel_b ? bus.i_b_addr : bus.i_a_addr;
        w_hazard   = w_wr_go & (w_rd_sel_a | w_rd_sel_b) & (w_wr_addr == w_rd_addr);
        w_rd_gnt_a = w_rd_sel_a & ~w_hazard;
        w_rd_gnt_b = w_rd_sel_b & ~w_hazard;
        w_rd_go    = w_rd_gnt_a | w_rd_gnt_b;
    end

    // Each client has one request, so it can hold at most one port grant
    assign bus.o_a_gnt = w_wr_gnt_a | w_rd_gnt_a;
    assign bus.o_b_gnt = w_wr_gnt_b | w_rd_gnt_b;

    // Round-robin pointers move to the other client after each grant on their port
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_pri <= CLI_A;
            r_rd_pri <= CLI_A;
        end else begin
            if (w_wr_go) begin
                r_wr_pri <= w_wr_gnt_a ? CLI_B : CLI_A;
            end
            if (w_rd_go) begin
                r_rd_pri <= w_rd_gnt_a ? CLI_B : CLI_A;
            end
        end
    end

    // RAM write port: strobe for one cycle per grant, address/data hold otherwise
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_dv   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_dv <= w_wr_go;
            if (w_wr_go) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= w_wr_data;
            end
        end
    end

    // RAM read port: enable for one cycle per grant, address holds otherwise
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_rd_en <= w_rd_go;
            if (w_rd_go) begin
                r_rd_addr <= w_rd_addr;
            end
        end
    end

    // Tag pipeline follows each read from issue to RAM return; reset drops in-flight reads
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tag1_v  <= 1'b0;
            r_tag1_id <= CLI_A;
            r_tag2_v  <= 1'b0;
            r_tag2_id <= CLI_A;
        end else begin
            r_tag1_v  <= w_rd_go;
            r_tag1_id <= w_rd_gnt_b ? CLI_B : CLI_A;
            r_tag2_v  <= r_tag1_v;
            r_tag2_id <= r_tag1_id;
        end
    end

    // Route returned read data to the tagged client; untagged returns are ignored
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a_rd_dv   <= 1'b0;
            r_a_rd_data <= '0;
            r_b_rd_dv   <= 1'b0;
            r_b_rd_data <= '0;
        end else begin
            r_a_rd_dv <= 1'b0;
            r_b_rd_dv <= 1'b0;
            if (bus.i_rd_dv && r_tag2_v) begin
                if (r_tag2_id == CLI_A) begin
                    r_a_rd_dv   <= 1'b1;
                    r_a_rd_data <= bus.i_rd_data;
                end else begin
                    r_b_rd_dv   <= 1'b1;
                    r_b_rd_data <= bus.i_rd_data;
                end
            end
        end
    end

    assign bus.o_wr_addr   = r_wr_addr;
    assign bus.o_wr_dv     = r_wr_dv;
    assign bus.o_wr_data   = r_wr_data;
    assign bus.o_rd_addr   = r_rd_addr;
    assign bus.o_rd_en     = r_rd_en;
    assign bus.o_a_rd_dv   = r_a_rd_dv;
    assign bus.o_a_rd_data = r_a_rd_data;
    assign bus.o_b_rd_dv   = r_b_rd_dv;
    assign bus.o_b_rd_data = r_b_rd_data;

endmodule
